// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, owner encoding, width defaults.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/mem_lat_cnt.sv
// Access-latency counter: counts busy cycles and flags the last one (cnt == MEM_LAT-1).
module mem_lat_cnt #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [CW-1:0] cnt_q;

  assign last_o = en_i && (cnt_q == CW'(MEM_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt_q <= '0;
    else if (clr_i || last_o) cnt_q <= '0;
    else if (en_i)            cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported fixed-latency memory; data side has priority.
// Define ARB_FAIR_EN to force a fetch grant after FAIR_MAX data grants while fetch waits.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MEM_LAT  = 2,
  parameter int FAIR_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e            state_q;
  owner_e            own_q;
  logic              rdy_q, kill_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;
  logic              busy, last, fetch_ok, force_i, grant_d, grant_i;

  assign busy     = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign fetch_ok = i_req && !i_flush;
  assign grant_d  = (state_q == IDLE) && (d_re || d_we) && !force_i;
  assign grant_i  = (state_q == IDLE) && !grant_d && fetch_ok;

`ifdef ARB_FAIR_EN
  logic [2:0] fair_q;
  assign force_i = fetch_ok && (fair_q == 3'(FAIR_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      fair_q <= '0;
    else if (!i_req || grant_i)   fair_q <= '0;
    else if (grant_d && fetch_ok) fair_q <= fair_q + 3'd1;
  end
`else
  assign force_i = 1'b0;
`endif

  mem_lat_cnt #(.MEM_LAT(MEM_LAT)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == IDLE),
    .en_i   (busy),
    .last_o (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      own_q       <= OWN_I;
      rdy_q       <= 1'b0;
      kill_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (grant_d) begin
            state_q     <= BUSY_D;
            own_q       <= OWN_D;
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (grant_i) begin
            state_q    <= BUSY_I;
            own_q      <= OWN_I;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_addr;
          end
        end
        BUSY_I, BUSY_D: begin
          // A flush anywhere in a fetch access is remembered so the result is dropped.
          if (state_q == BUSY_I && i_flush) kill_q <= 1'b1;
          if (last) begin
            state_q  <= DONE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (state_q == BUSY_D) begin
              rdy_q <= 1'b1;
              if (!mem_we_q) d_rdata_q <= mem_rdata;
            end else if (!(kill_q || i_flush)) begin
              rdy_q     <= 1'b1;
              i_rdata_q <= mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush arriving in the DONE cycle still cancels the scheduled fetch pulse.
  assign i_ready   = rdy_q && (own_q == OWN_I) && !i_flush;
  assign d_ready   = rdy_q && (own_q == OWN_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule
